// File: rtl/core_tlb_search_arb_pkg.sv
// Shared TLB search types: search result, requester identity and the
// per-stage tag carried alongside an in-flight search.
package core_tlb_search_arb_pkg;

    localparam int VPPN_W = 20;

    // Result returned by the TLB array search port.
    typedef struct packed {
        logic        found;
        logic [3:0]  index;
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_s_resp_t;

    // Which translator issued a search.
    typedef enum logic {
        TLB_OWN_I = 1'b0,
        TLB_OWN_D = 1'b1
    } tlb_owner_e;

    // One slot of the response routing pipeline.
    typedef struct packed {
        logic       valid;
        tlb_owner_e owner;
    } tlb_arb_tag_t;

endpackage

// File: rtl/core_tlb_search_arb_rr_arb2.sv
// Two-input round-robin arbiter. Port 0 and port 1 compete; with both
// requesting, the port that did not win last time gets the grant. The
// pointer only moves when a grant is actually given (en_i high).
module core_rr_arb2 #(
    parameter logic RESET_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic last_q;

    // Grant selection: contention resolved against the last winner.
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                grant_o = last_q ? 2'b01 : 2'b10;
            end else begin
                grant_o = req_i;
            end
        end
    end

    // Remember the side that was granted; hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= RESET_LAST;
        end else if (|grant_o) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/core_tlb_search_arb.sv
// Shares the TLB search port between the fetch-side (I) and data-side (D)
// translators. A round-robin grant picks one search per cycle; a tag
// pipeline of LATENCY stages remembers who issued each search so the
// unregistered TLB result can be flagged valid for the right requester.
//
// Handshake: a request transfers in any cycle where x_req_valid_i and
// x_req_ready_o are both high. Requesters keep valid and vppn stable until
// that happens; ready never depends on valid of the same side's response.
module core_tlb_search_arb
    import core_tlb_search_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid_i,
    input  logic [VPPN_W-1:0] i_req_vppn_i,
    output logic              i_req_ready_o,
    output logic              i_resp_valid_o,
    output tlb_s_resp_t       i_resp_o,
    input  logic              d_req_valid_i,
    input  logic [VPPN_W-1:0] d_req_vppn_i,
    output logic              d_req_ready_o,
    output logic              d_resp_valid_o,
    output tlb_s_resp_t       d_resp_o,
    input  logic              flush_i,
    output logic              tlb_req_valid_o,
    output logic [VPPN_W-1:0] tlb_req_vppn_o,
    input  logic              tlb_req_ready_i,
    input  tlb_s_resp_t       tlb_resp_i
);

    logic         grant_en;
    logic [1:0]   grant;
    logic         accept;
    tlb_owner_e   grant_owner;
    tlb_arb_tag_t tag_vec [LATENCY];
    tlb_arb_tag_t tag_last;
    logic         resp_live;

    // Nothing may be granted while the TLB is busy, during a flush or in reset.
    assign grant_en = tlb_req_ready_i & ~flush_i & ~rst;

    // D is the reset "last winner" so I wins the first contention.
    core_rr_arb2 #(
        .RESET_LAST (1'b1)
    ) u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({d_req_valid_i, i_req_valid_i}),
        .en_i    (grant_en),
        .grant_o (grant)
    );

    // A grant is only ever given to a valid requester, so grant == accept.
    assign i_req_ready_o   = grant[0];
    assign d_req_ready_o   = grant[1];
    assign accept          = |grant;
    assign grant_owner     = grant[1] ? TLB_OWN_D : TLB_OWN_I;
    assign tlb_req_valid_o = accept;

    // Route the granted vppn to the TLB; idle bus reads as zero.
    always_comb begin
        tlb_req_vppn_o = '0;
        if (grant[0]) begin
            tlb_req_vppn_o = i_req_vppn_i;
        end else if (grant[1]) begin
            tlb_req_vppn_o = d_req_vppn_i;
        end
    end

    // Tag pipeline: stage 0 captures the accepted search, later stages shift.
    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        tlb_arb_tag_t tag_q;

        // Shift one stage per cycle; a flush kills every tag at once.
        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                tag_q <= '{valid: 1'b0, owner: TLB_OWN_I};
            end else if (g == 0) begin
                tag_q <= '{valid: accept, owner: grant_owner};
            end else begin
                tag_q <= tag_vec[(g == 0) ? 0 : g - 1];
            end
        end

        assign tag_vec[g] = tag_q;
    end

    assign tag_last = tag_vec[LATENCY-1];

    // A flush in the same cycle as a returning result suppresses it too.
    assign resp_live      = tag_last.valid & ~flush_i & ~rst;
    assign i_resp_valid_o = resp_live & (tag_last.owner == TLB_OWN_I);
    assign d_resp_valid_o = resp_live & (tag_last.owner == TLB_OWN_D);

    // Result data is passed straight through to both sides.
    assign i_resp_o = tlb_resp_i;
    assign d_resp_o = tlb_resp_i;

endmodule

// File: tb/tb_core_tlb_search_arb.sv
// Bench for core_tlb_search_arb: three instances (LATENCY 1, 2, 3) share
// one stimulus stream. A reference arbiter predicts grants; each accepted
// search pushes one expected response per latency into exp_q, which is
// popped when its due cycle arrives.
module tb_core_tlb_search_arb;
    import core_tlb_search_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_v, d_v, flush, rdy;
    logic [19:0] i_vp, d_vp;
    tlb_s_resp_t resp;

    logic        ir [3];
    logic        dr [3];
    logic        tv [3];
    logic [19:0] vp [3];
    logic        iv [3];
    logic        dv [3];
    tlb_s_resp_t irs [3];
    tlb_s_resp_t drs [3];

    core_tlb_search_arb #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .i_req_valid_i(i_v), .i_req_vppn_i(i_vp), .i_req_ready_o(ir[0]),
        .i_resp_valid_o(iv[0]), .i_resp_o(irs[0]),
        .d_req_valid_i(d_v), .d_req_vppn_i(d_vp), .d_req_ready_o(dr[0]),
        .d_resp_valid_o(dv[0]), .d_resp_o(drs[0]),
        .flush_i(flush), .tlb_req_valid_o(tv[0]), .tlb_req_vppn_o(vp[0]),
        .tlb_req_ready_i(rdy), .tlb_resp_i(resp)
    );

    core_tlb_search_arb #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .i_req_valid_i(i_v), .i_req_vppn_i(i_vp), .i_req_ready_o(ir[1]),
        .i_resp_valid_o(iv[1]), .i_resp_o(irs[1]),
        .d_req_valid_i(d_v), .d_req_vppn_i(d_vp), .d_req_ready_o(dr[1]),
        .d_resp_valid_o(dv[1]), .d_resp_o(drs[1]),
        .flush_i(flush), .tlb_req_valid_o(tv[1]), .tlb_req_vppn_o(vp[1]),
        .tlb_req_ready_i(rdy), .tlb_resp_i(resp)
    );

    core_tlb_search_arb #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .i_req_valid_i(i_v), .i_req_vppn_i(i_vp), .i_req_ready_o(ir[2]),
        .i_resp_valid_o(iv[2]), .i_resp_o(irs[2]),
        .d_req_valid_i(d_v), .d_req_vppn_i(d_vp), .d_req_ready_o(dr[2]),
        .d_resp_valid_o(dv[2]), .d_resp_o(drs[2]),
        .flush_i(flush), .tlb_req_valid_o(tv[2]), .tlb_req_vppn_o(vp[2]),
        .tlb_req_ready_i(rdy), .tlb_resp_i(resp)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic m_last = 1'b1;               // 1 = D won last
    logic m_acc_i, m_acc_d;
    logic [18:0] exp_q[$];             // {lat_idx[1:0], due[15:0], owner}

    logic        obs_ir, obs_dr;
    logic [19:0] obs_vp;
    logic        obs_iv [3];
    logic        obs_dv [3];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: drive, check against prediction, update the model.
    task automatic step(input logic ival, input logic [19:0] ivp,
                        input logic dval, input logic [19:0] dvp,
                        input logic r_rdy, input logic fl, input logic r_rst);
        logic        en, gi, gd;
        logic [19:0] evp;
        logic        ei [3];
        logic        ed [3];
        logic [18:0] keep[$];
        logic [31:0] rr;
        @(negedge clk);
        i_v = ival; i_vp = ivp; d_v = dval; d_vp = dvp;
        rdy = r_rdy; flush = fl; rst = r_rst;
        rr = $urandom;
        resp = rr[30:0];
        #1;
        en  = r_rdy & ~fl & ~r_rst;
        gi  = en & ival & (~dval | m_last);
        gd  = en & dval & (~ival | ~m_last);
        evp = gi ? ivp : (gd ? dvp : 20'h0);
        if (fl || r_rst) exp_q.delete();
        for (int l = 0; l < 3; l++) begin
            ei[l] = 1'b0;
            ed[l] = 1'b0;
        end
        foreach (exp_q[n]) begin
            if (exp_q[n][16:1] == 16'(cyc)) begin
                if (exp_q[n][0]) ed[exp_q[n][18:17]] = 1'b1;
                else             ei[exp_q[n][18:17]] = 1'b1;
            end else begin
                keep.push_back(exp_q[n]);
            end
        end
        exp_q = keep;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("i_ready_L%0d", k + 1), 32'(ir[k]), 32'(gi));
            check_val($sformatf("d_ready_L%0d", k + 1), 32'(dr[k]), 32'(gd));
            check_val($sformatf("tlb_valid_L%0d", k + 1), 32'(tv[k]), 32'(gi | gd));
            check_val($sformatf("tlb_vppn_L%0d", k + 1), 32'(vp[k]), 32'(evp));
            check_val($sformatf("i_resp_valid_L%0d", k + 1), 32'(iv[k]), 32'(ei[k]));
            check_val($sformatf("d_resp_valid_L%0d", k + 1), 32'(dv[k]), 32'(ed[k]));
            check_val($sformatf("i_resp_L%0d", k + 1), 32'(irs[k]), 32'(resp));
            check_val($sformatf("d_resp_L%0d", k + 1), 32'(drs[k]), 32'(resp));
            obs_iv[k] = iv[k];
            obs_dv[k] = dv[k];
        end
        obs_ir = ir[0];
        obs_dr = dr[0];
        obs_vp = vp[0];
        if (gi || gd) begin
            for (int l = 0; l < 3; l++) exp_q.push_back({2'(l), 16'(cyc + l + 1), gd});
        end
        if (gi)      m_last = 1'b0;
        else if (gd) m_last = 1'b1;
        if (r_rst)   m_last = 1'b1;
        m_acc_i = gi;
        m_acc_d = gd;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  g [4];
        logic        got;
        logic        hi, hd, rr_rdy, rr_fl;
        logic [19:0] hvi, hvd;

        rst = 1'b1; i_v = 1'b0; d_v = 1'b0; i_vp = '0; d_vp = '0;
        flush = 1'b0; rdy = 1'b1; resp = '0;

        // reset state
        step(1'b1, 20'h12345, 1'b1, 20'h54321, 1'b1, 1'b0, 1'b1);
        step(1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1);

        // single I request
        step(1'b1, 20'h1C000, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
        check_val("single_i_ready", 32'(obs_ir), 32'd1);
        check_val("single_vppn", 32'(obs_vp), 32'h1C000);
        step(1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
        check_val("single_i_resp_L1", 32'(obs_iv[0]), 32'd1);
        check_val("single_d_resp_L1", 32'(obs_dv[0]), 32'd0);
        idle(3);

        // contention after reset: I, D, I, D
        step(1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 20'h11111 + 20'(k), 1'b1, 20'h22222 + 20'(k), 1'b1, 1'b0, 1'b0);
            g[k] = {obs_ir, obs_dr};
        end
        check_val("cont_g0", 32'(g[0]), 32'h2);
        check_val("cont_g1", 32'(g[1]), 32'h1);
        check_val("cont_g2", 32'(g[2]), 32'h2);
        check_val("cont_g3", 32'(g[3]), 32'h1);
        idle(4);

        // flush in flight (also suppresses the L1 result due in the flush cycle)
        step(1'b1, 20'hABCDE, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 20'hABCDF, 1'b0, 20'h0, 1'b1, 1'b1, 1'b0);
        check_val("flush_no_accept", 32'(obs_ir), 32'd0);
        check_val("flush_l1_suppress", 32'(obs_iv[0]), 32'd0);
        step(1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
        check_val("flush_l2_suppress", 32'(obs_iv[1]), 32'd0);
        idle(3);

        // TLB busy with D waiting (last winner is I here)
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 20'h0, 1'b1, 20'h0D00D, 1'b0, 1'b0, 1'b0);
            check_val("busy_d_ready", 32'(obs_dr), 32'd0);
        end
        step(1'b0, 20'h0, 1'b1, 20'h0D00D, 1'b1, 1'b0, 1'b0);
        check_val("busy_d_accept", 32'(obs_dr), 32'd1);
        // pointer must hold while busy; results of D still return meanwhile
        step(1'b1, 20'h00A01, 1'b1, 20'h00B01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 20'h00A01, 1'b1, 20'h00B01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 20'h00A01, 1'b1, 20'h00B01, 1'b1, 1'b0, 1'b0);
        check_val("busy_ptr_hold", 32'({obs_ir, obs_dr}), 32'h2);
        idle(4);

        // reset mid-operation with two searches in flight
        step(1'b1, 20'h33333, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 20'h0, 1'b1, 20'h44444, 1'b1, 1'b0, 1'b0);
        step(1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check_val("rst_no_resp_L3", 32'({obs_iv[2], obs_dv[2]}), 32'd0);
        end
        step(1'b1, 20'h55555, 1'b1, 20'h66666, 1'b1, 1'b0, 1'b0);
        check_val("rst_then_i_wins", 32'({obs_ir, obs_dr}), 32'h2);
        idle(4);

        // starvation bound: D held, I toggling
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(~k[0], 20'h77770 + 20'(k), 1'b1, 20'h88888, 1'b1, 1'b0, 1'b0);
            if (k < 2) got = got | obs_dr;
        end
        check_val("starve_d_within2", 32'(got), 32'd1);
        idle(4);

        // random traffic with held requests, TLB busy and occasional flush
        hi = 1'b0; hd = 1'b0; hvi = '0; hvd = '0;
        m_acc_i = 1'b0; m_acc_d = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!hi || m_acc_i) begin
                hi  = 1'($urandom_range(0, 1));
                hvi = 20'($urandom);
            end
            if (!hd || m_acc_d) begin
                hd  = 1'($urandom_range(0, 1));
                hvd = 20'($urandom);
            end
            rr_rdy = ($urandom_range(0, 3) != 0);
            rr_fl  = ($urandom_range(0, 15) == 0);
            step(hi, hvi, hd, hvd, rr_rdy, rr_fl, 1'b0);
        end
        idle(4);
        check_val("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
